cond_final_sub: RTL and testbench

COND_FINAL_SUB -- requirements
Module: cond_final_sub

---
 rtl/cond_final_sub.sv | 110 +++++++++++
 tb/tb_cond_final_sub.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cond_final_sub.sv
// cond_final_sub: digit-serial T-N with conditional final reduction,
// the closing step of a Montgomery multiplication.
module cond_final_sub #(
   parameter int K_BITS     = 8,
   parameter int DIGIT_BITS = 3
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [K_BITS:0]   i_T,
   input  logic [K_BITS:0]   i_N,
   output logic              o_busy,
   output logic              o_done,
   output logic [K_BITS:0]   o_Diff,
   output logic              o_borrow,
   output logic [K_BITS:0]   o_Result
);

   localparam int W          = K_BITS + 1;
   localparam int D          = DIGIT_BITS;
   localparam int NUM_DIGITS = (K_BITS + 1) / DIGIT_BITS;
   localparam int CW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    t_q, n_q, diff_q, diff_nx;
   logic [CW-1:0]   cnt_q;
   logic            borrow_q;
   logic [D-1:0]    t_dig, n_dig;
   logic [D:0]      sub;
   logic            last;

   // Select the current digit and splice its difference into the word
   always_comb begin
      t_dig   = '0;
      n_dig   = '0;
      diff_nx = diff_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (cnt_q == CW'(i)) begin
            t_dig = t_q[i*D +: D];
            n_dig = n_q[i*D +: D];
         end
      end
      sub = {1'b0, t_dig} - {1'b0, n_dig} - {{D{1'b0}}, borrow_q};
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (cnt_q == CW'(i)) begin
            diff_nx[i*D +: D] = sub[D-1:0];
         end
      end
      last = (cnt_q == CW'(NUM_DIGITS - 1));
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (i_start) state_d = SUB;
         SUB:     if (last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         t_q      <= '0;
         n_q      <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         borrow_q <= 1'b0;
         o_done   <= 1'b0;
         o_Diff   <= '0;
         o_borrow <= 1'b0;
         o_Result <= '0;
      end else begin
         o_done <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (i_start) begin
                  t_q      <= i_T;
                  n_q      <= i_N;
                  diff_q   <= '0;
                  cnt_q    <= '0;
                  borrow_q <= 1'b0;
               end
            end
            SUB: begin
               diff_q   <= diff_nx;
               borrow_q <= sub[D];
               cnt_q    <= cnt_q + CW'(1);
               if (last) begin
                  o_Diff   <= diff_nx;
                  o_borrow <= sub[D];
                  o_Result <= sub[D] ? t_q : diff_nx;
                  o_done   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_busy = (state_q != IDLE);

endmodule

// File: tb/tb_cond_final_sub.sv
// Bench for cond_final_sub: directed vectors, abort and
// random back-to-back operations against an arithmetic model.
module tb_cond_final_sub;

   localparam int K = 8;
   localparam int D = 3;
   localparam int M = 512;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [K:0]    t_in = '0;
   logic [K:0]    n_in = '0;
   logic          busy, done, borrow;
   logic [K:0]    diff, result;

   int errors = 0;
   int checks = 0;

   cond_final_sub #(.K_BITS(K), .DIGIT_BITS(D)) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_start  (start),
      .i_T      (t_in),
      .i_N      (n_in),
      .o_busy   (busy),
      .o_done   (done),
      .o_Diff   (diff),
      .o_borrow (borrow),
      .o_Result (result)
   );

   always #5 clk = ~clk;

   function automatic logic [K:0] m_diff(input logic [K:0] t, input logic [K:0] n);
      int v;
      v = ((int'(t) - int'(n)) % M + M) % M;
      return v[K:0];
   endfunction

   // Called at a negedge; returns at the negedge where done is seen
   task automatic do_op(input logic [K:0] t, input logic [K:0] n, output int lat);
      t_in  = t;
      n_in  = n;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t_in  = 9'($urandom);
      n_in  = 9'($urandom);
      lat = 0;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, borrow, diff, result} !== '0) begin
         errors++;
         $display("FAIL reset_state got busy=%b done=%b diff=%0d b=%b res=%0d want all 0",
                  busy, done, diff, borrow, result);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_vectors();
      logic [K:0] tv [6] = '{9'd100, 9'd50, 9'd511, 9'd10, 9'd0, 9'd256};
      logic [K:0] nv [6] = '{9'd25, 9'd50, 9'd511, 9'd20, 9'd1, 9'd1};
      for (int i = 0; i < 6; i++) begin
         int lat;
         logic [K:0] ed;
         logic eb;
         ed = m_diff(tv[i], nv[i]);
         eb = (tv[i] < nv[i]);
         do_op(tv[i], nv[i], lat);
         checks++;
         if (lat !== 3) begin
            errors++;
            $display("FAIL latency_%0d got %0d want 3", i, lat);
         end
         checks++;
         if (diff !== ed || borrow !== eb || result !== (eb ? tv[i] : ed)) begin
            errors++;
            $display("FAIL vec_%0d T=%0d N=%0d got diff=%0d b=%b res=%0d want %0d %b %0d",
                     i, tv[i], nv[i], diff, borrow, result, ed, eb, eb ? tv[i] : ed);
         end
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_width_%0d got done=%b busy=%b want 0 0", i, done, busy);
         end
      end
   endtask

   task automatic test_start_ignored();
      int pulses = 0;
      t_in  = 9'd256;
      n_in  = 9'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      t_in  = 9'd5;
      n_in  = 9'd9;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_mid_sub got %b want 1", busy);
      end
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      checks++;
      if (pulses !== 1) begin
         errors++;
         $display("FAIL ignored_start_pulses got %0d want 1", pulses);
      end
      checks++;
      if (diff !== 9'd255 || borrow !== 1'b0 || result !== 9'd255) begin
         errors++;
         $display("FAIL ignored_start_result got diff=%0d b=%b res=%0d want 255 0 255",
                  diff, borrow, result);
      end
   endtask

   task automatic test_reset_abort();
      int pulses = 0;
      int lat;
      t_in  = 9'd150;
      n_in  = 9'd160;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({busy, done, borrow, diff, result} !== '0) begin
         errors++;
         $display("FAIL abort_state got busy=%b done=%b diff=%0d b=%b res=%0d want all 0",
                  busy, done, diff, borrow, result);
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         errors++;
         $display("FAIL abort_pulses got %0d want 0", pulses);
      end
      do_op(9'd150, 9'd160, lat);
      checks++;
      if (lat !== 3 || diff !== 9'd502 || borrow !== 1'b1 || result !== 9'd150) begin
         errors++;
         $display("FAIL after_abort got lat=%0d diff=%0d b=%b res=%0d want 3 502 1 150",
                  lat, diff, borrow, result);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 1000; i++) begin
         int lat;
         logic [K:0] t, n, ed;
         logic eb;
         t  = 9'($urandom);
         n  = (i % 10 == 0) ? t : 9'($urandom);
         ed = m_diff(t, n);
         eb = (t < n);
         do_op(t, n, lat);
         checks++;
         if (lat !== 3 || diff !== ed || borrow !== eb || result !== (eb ? t : ed)) begin
            errors++;
            $display("FAIL b2b_%0d T=%0d N=%0d got lat=%0d diff=%0d b=%b res=%0d want 3 %0d %b %0d",
                     i, t, n, lat, diff, borrow, result, ed, eb, eb ? t : ed);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_start_ignored();
      test_reset_abort();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
